prm_mask_scan: RTL and testbench

PRM_MASK_SCAN -- requirements
Module: prm_mask_scan

---
 rtl/prm_mask_scan.sv | 142 ++++++++++++++
 tb/tb_prm_mask_scan.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_mask_scan.sv
// Coordinate scanner: walks a packed {x,y,z} range, samples one selected
// edge-mask bit per point, and reports the hit count and first hit coordinate.
module prm_mask_scan #(
    parameter int XW     = 4,
    parameter int YW     = 5,
    parameter int ZW     = 5,
    parameter int NCH    = 8,
    parameter int MW     = 512,
    parameter int SETTLE = 1,
    parameter int RW     = 32
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(NCH)-1:0]    sel_ch,
    input  logic [$clog2(MW)-1:0]     sel_bit,
    input  logic [XW+YW+ZW-1:0]       xyz_start,
    input  logic [XW+YW+ZW:0]         xyz_cnt,
    input  logic [NCH*MW-1:0]         edge_mask,
    output logic [XW-1:0]             x,
    output logic [YW-1:0]             y,
    output logic [ZW-1:0]             z,
    output logic                      busy,
    output logic                      done,
    output logic [RW-1:0]             hit_cnt,
    output logic [XW+YW+ZW-1:0]       first_hit,
    output logic                      first_valid
);

    localparam int N  = XW + YW + ZW;
    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(MW);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SLOAD   = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
    localparam logic [N:0]    ONE_LEFT = (N+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    xyz;
    logic [CW-1:0]   lat_ch;
    logic [BW-1:0]   lat_bit;
    logic [N:0]      remain;
    logic [SW-1:0]   settle_cnt;
    logic [CW+BW-1:0] bit_idx;
    logic            sampled;

    assign {x, y, z} = xyz;

    // MW is a power of two, so {channel, bit} is the flat mask index.
    assign bit_idx = {lat_ch, lat_bit};
    assign sampled = (32'(lat_ch) < NCH) ? edge_mask[bit_idx] : 1'b0;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            xyz         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_cnt     <= '0;
            first_hit   <= '0;
            first_valid <= 1'b0;
            lat_ch      <= '0;
            lat_bit     <= '0;
            remain      <= '0;
            settle_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_ch      <= sel_ch;
                        lat_bit     <= sel_bit;
                        remain      <= xyz_cnt;
                        xyz         <= xyz_start;
                        hit_cnt     <= '0;
                        first_hit   <= '0;
                        first_valid <= 1'b0;
                        busy        <= 1'b1;
                        settle_cnt  <= SLOAD;
                        if (xyz_cnt == '0)
                            state <= ST_DONE;
                        else if (SETTLE > 0)
                            state <= ST_SETTLE;
                        else
                            state <= ST_SAMPLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (sampled) begin
                            if (hit_cnt != '1)
                                hit_cnt <= hit_cnt + 1'b1;
                            if (!first_valid) begin
                                first_hit   <= xyz;
                                first_valid <= 1'b1;
                            end
                        end
                        xyz        <= xyz + 1'b1;
                        remain     <= remain - 1'b1;
                        settle_cnt <= SLOAD;
                        if (remain == ONE_LEFT)
                            state <= ST_DONE;
                        else if (SETTLE > 0)
                            state <= ST_SETTLE;
                        else
                            state <= ST_SAMPLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prm_mask_scan.sv
// Self-checking bench for prm_mask_scan: table of directed and randomized scans
// checked against a coordinate-walking reference model, plus abort/reset sequences.
module tb_prm_mask_scan;

    localparam int XW     = 4;
    localparam int YW     = 5;
    localparam int ZW     = 5;
    localparam int NCH    = 8;
    localparam int MW     = 512;
    localparam int SETTLE = 1;
    localparam int RW     = 32;
    localparam int N      = XW + YW + ZW;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [2:0]        sel_ch = '0;
    logic [8:0]        sel_bit = '0;
    logic [N-1:0]      xyz_start = '0;
    logic [N:0]        xyz_cnt = '0;
    logic [NCH*MW-1:0] edge_mask;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ZW-1:0]     z;
    logic              busy;
    logic              done;
    logic [RW-1:0]     hit_cnt;
    logic [N-1:0]      first_hit;
    logic              first_valid;

    int          mode = 2;
    int unsigned seed = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [N-1:0] xs;
        logic [N:0]   cnt;
        logic [2:0]   ch;
        logic [8:0]   b;
        int           mode;
        int unsigned  seed;
        int unsigned  e_hits;
        logic [N-1:0] e_fh;
        logic         e_fv;
        int           e_lat;
    } vec_t;

    vec_t vecs[$];

    prm_mask_scan #(
        .XW(XW), .YW(YW), .ZW(ZW), .NCH(NCH), .MW(MW), .SETTLE(SETTLE), .RW(RW)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort),
        .sel_ch(sel_ch), .sel_bit(sel_bit), .xyz_start(xyz_start), .xyz_cnt(xyz_cnt),
        .edge_mask(edge_mask), .x(x), .y(y), .z(z), .busy(busy), .done(done),
        .hit_cnt(hit_cnt), .first_hit(first_hit), .first_valid(first_valid)
    );

    always #5 CLK = ~CLK;

    // Mask generator: bit (ch,b) as a function of the currently driven coordinate.
    function automatic bit mbit(input int m, input int unsigned s, input int unsigned ch,
                                input int unsigned b, input int unsigned c);
        int unsigned h;
        h = 0;
        case (m)
            0: begin
                h = (c * 32'h9E3779B1) ^ (ch * 32'h85EBCA6B) ^ (b * 32'hC2B2AE35) ^ s;
                h = h ^ (h >> 15);
                h = h * 32'h2C1B3C6D;
                h = h ^ (h >> 12);
                return h[9];
            end
            1: return (ch == 2) && (b == 5) && (c == 2);
            2: return 1'b1;
            3: return ch == 1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NCH * MW; i++)
            edge_mask[i[11:0]] = mbit(mode, seed, i / MW, i % MW, 32'({x, y, z}));
    end

    function automatic vec_t with_model(input vec_t v);
        vec_t r;
        int unsigned c;
        r = v;
        r.e_hits = 0;
        r.e_fv   = 1'b0;
        r.e_fh   = '0;
        for (int i = 0; i < int'(v.cnt); i++) begin
            c = (32'(v.xs) + i) % (1 << N);
            if (mbit(v.mode, v.seed, v.ch, v.b, c)) begin
                r.e_hits++;
                if (!r.e_fv) begin
                    r.e_fv = 1'b1;
                    r.e_fh = N'(c);
                end
            end
        end
        r.e_lat = int'(v.cnt) * (SETTLE + 1) + 1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int           lat;
        bit           seen;
        bit           seq_ok;
        logic [N-1:0] cur;
        logic [N-1:0] q[$];
        @(negedge CLK);
        mode      = v.mode;
        seed      = v.seed;
        sel_ch    = v.ch;
        sel_bit   = v.b;
        xyz_start = v.xs;
        xyz_cnt   = v.cnt;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat   = 0;
        chk($sformatf("%s_busy_after_accept", tag), busy, 1);
        q.push_back({x, y, z});
        seen = done;
        while (!seen && lat < v.e_lat + 10) begin
            @(negedge CLK);
            lat++;
            cur = {x, y, z};
            if (cur != q[$]) q.push_back(cur);
            seen = done;
        end
        chk($sformatf("%s_latency", tag), seen ? lat : 99999, v.e_lat);
        chk($sformatf("%s_busy_at_done", tag), busy, 0);
        chk($sformatf("%s_hit_cnt", tag), hit_cnt, v.e_hits);
        chk($sformatf("%s_first_valid", tag), first_valid, v.e_fv);
        chk($sformatf("%s_first_hit", tag), first_hit, v.e_fh);
        seq_ok = (q.size() == int'(v.cnt) + 1);
        if (seq_ok)
            foreach (q[i]) if (q[i] != N'(32'(v.xs) + i)) seq_ok = 1'b0;
        chk($sformatf("%s_coord_seq", tag), seq_ok, 1);
        if (seen) begin
            @(negedge CLK);
            chk($sformatf("%s_done_one_cycle", tag), done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   n_done;
        int   n_busy;
        vec_t v;

        // Directed scans with hand-derived results.
        vecs.push_back('{14'd0,     15'd4, 3'd2, 9'd5,   1, 0, 1, 14'd2,     1'b1, 9});
        vecs.push_back('{14'h1234,  15'd0, 3'd4, 9'd17,  2, 0, 0, 14'd0,     1'b0, 1});
        vecs.push_back('{14'd16382, 15'd4, 3'd3, 9'd100, 2, 0, 4, 14'd16382, 1'b1, 9});
        vecs.push_back('{14'd5,     15'd1, 3'd7, 9'd511, 2, 0, 1, 14'd5,     1'b1, 3});
        vecs.push_back('{14'd0,     15'd4, 3'd2, 9'd6,   1, 0, 0, 14'd0,     1'b0, 9});
        vecs.push_back('{14'd0,     15'd4, 3'd3, 9'd5,   1, 0, 0, 14'd0,     1'b0, 9});
        vecs.push_back('{14'd40,    15'd3, 3'd1, 9'd0,   3, 0, 3, 14'd40,    1'b1, 7});
        vecs.push_back('{14'd40,    15'd3, 3'd6, 9'd0,   3, 0, 0, 14'd0,     1'b0, 7});
        for (int k = 0; k < 12; k++) begin
            v.xs   = (k % 3 == 0) ? N'(16384 - $urandom_range(1, 8)) : N'($urandom);
            v.cnt  = (N+1)'($urandom_range(0, 20));
            v.ch   = 3'($urandom);
            v.b    = 9'($urandom);
            v.mode = 0;
            v.seed = $urandom;
            vecs.push_back(with_model(v));
        end

        #1 RST_n = 1'b0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_first_valid", first_valid, 0);
        chk("reset_first_hit", first_hit, 0);
        chk("reset_xyz", {x, y, z}, 0);
        #9 RST_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start pulsed mid-scan with another channel must be ignored.
        @(negedge CLK);
        mode = 3; sel_ch = 3'd1; sel_bit = 9'd7; xyz_start = 14'd100; xyz_cnt = 15'd6; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(negedge CLK); lat++; end
        sel_ch = 3'd0; sel_bit = 9'd3; xyz_start = 14'd0; xyz_cnt = 15'd2; start = 1'b1;
        @(negedge CLK);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge CLK); lat++; end
        chk("midstart_latency", done ? lat : 99999, 13);
        chk("midstart_hit_cnt", hit_cnt, 6);
        chk("midstart_first_hit", first_hit, 100);
        chk("midstart_first_valid", first_valid, 1);

        // Abort in the settle phase after two samples; start in the same cycle loses.
        @(negedge CLK);
        mode = 2; sel_ch = 3'd5; sel_bit = 9'd9; xyz_start = 14'd50; xyz_cnt = 15'd10; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat = 0;
        while (hit_cnt != 2 && lat < 30) begin @(negedge CLK); lat++; end
        chk("abort_two_samples_at", lat, 4);
        abort = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hit_cnt", hit_cnt, 2);
        chk("abort_first_hit", first_hit, 50);
        chk("abort_first_valid", first_valid, 1);
        chk("abort_xyz_hold", {x, y, z}, 52);
        n_done = 0;
        n_busy = 0;
        repeat (15) begin
            @(negedge CLK);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_stays_idle", n_busy, 0);
        chk("abort_hit_cnt_hold", hit_cnt, 2);

        // Abort in the sample cycle: that sample must not be taken.
        @(negedge CLK);
        xyz_start = 14'd200; xyz_cnt = 15'd5; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_sample_busy", busy, 0);
        chk("abort_sample_hit_cnt", hit_cnt, 0);
        chk("abort_sample_first_valid", first_valid, 0);
        chk("abort_sample_xyz", {x, y, z}, 200);
        n_done = 0;
        repeat (6) begin
            @(negedge CLK);
            if (done) n_done++;
        end
        chk("abort_sample_no_done", n_done, 0);

        // Reset asserted during the settle phase of a scan.
        @(negedge CLK);
        xyz_start = 14'd300; xyz_cnt = 15'd5; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_pre_hit_cnt", hit_cnt, 1);
        RST_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hit_cnt", hit_cnt, 0);
        chk("midrst_first_valid", first_valid, 0);
        chk("midrst_first_hit", first_hit, 0);
        chk("midrst_xyz", {x, y, z}, 0);
        @(negedge CLK);
        #2 RST_n = 1'b1;
        run_vec('{14'd7, 15'd3, 3'd0, 9'd1, 2, 0, 3, 14'd7, 1'b1, 7}, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
